// File: rtl/hazard_forward_unit.sv
// Load-use stall, operand forwarding and IF/ID/EX flush control for the 5-stage RV32I pipe.
// Keeps a shadow of rd/op for EX and MEM so the decisions need only ID-stage inputs.
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic [REG_W-1:0] rd_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [1:0]       hazard_optype_ID,
    input  logic             Branch_ID,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic             PC_EN_IF,
    output logic             reg_FD_EN,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    logic [REG_W-1:0] rd_EX, rs2_EX, rd_MEM;
    logic [1:0]       op_EX, op_MEM;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             match1_ex, match2_ex, match1_mem, match2_mem;
    logic             stall, fd_flush, ls_fwd;

    assign match1_ex  = rs1use_ID & (rd_EX  != '0) & (rs1_ID == rd_EX);
    assign match2_ex  = rs2use_ID & (rd_EX  != '0) & (rs2_ID == rd_EX);
    assign match1_mem = rs1use_ID & (rd_MEM != '0) & (rs1_ID == rd_MEM);
    assign match2_mem = rs2use_ID & (rd_MEM != '0) & (rs2_ID == rd_MEM);

    // A store that only needs load data on rs2 proceeds; MEM-stage forwarding covers it.
    assign stall    = (op_EX == OP_LOAD) &
                      (match1_ex | (match2_ex & (hazard_optype_ID != OP_STORE)));
    assign fd_flush = Branch_ID & ~stall;
    assign ls_fwd   = (op_EX == OP_STORE) & (op_MEM == OP_LOAD) &
                      (rd_MEM != '0) & (rs2_EX == rd_MEM);

    function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem,
                                           input logic [1:0] opx, input logic [1:0] opm);
        if (m_ex && opx == OP_ALU)   return 2'b01;
        if (m_mem && opm == OP_ALU)  return 2'b10;
        if (m_mem && opm == OP_LOAD) return 2'b11;
        return 2'b00;
    endfunction

    // Outputs are forced to their idle values while reset is held, independent of inputs.
    always_comb begin
        forward_ctrl_A  = 2'b00;
        forward_ctrl_B  = 2'b00;
        forward_ctrl_ls = 1'b0;
        PC_EN_IF        = 1'b1;
        reg_FD_EN       = 1'b1;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        if (rst_n) begin
            forward_ctrl_A  = fwd_sel(match1_ex, match1_mem, op_EX, op_MEM);
            forward_ctrl_B  = fwd_sel(match2_ex, match2_mem, op_EX, op_MEM);
            forward_ctrl_ls = ls_fwd;
            PC_EN_IF        = ~stall;
            reg_FD_EN       = ~stall;
            reg_FD_flush    = fd_flush;
            reg_DE_flush    = stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_EX   <= '0;
            rs2_EX  <= '0;
            op_EX   <= 2'b00;
            rd_MEM  <= '0;
            op_MEM  <= 2'b00;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            rd_MEM <= rd_EX;
            op_MEM <= op_EX;
            if (stall) begin
                op_EX  <= 2'b00;
                rd_EX  <= '0;
                rs2_EX <= '0;
            end else begin
                op_EX  <= hazard_optype_ID;
                rd_EX  <= rd_ID;
                rs2_EX <= rs2_ID;
            end
            if (stall && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (fd_flush && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: vector table, hand sequences and random traffic vs a pipeline model.
module tb_hazard_forward_unit;

    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2;
        logic [1:0] op;
        logic       br;
    } instr_t;

    typedef struct {
        logic [1:0] op;
        logic [4:0] rd, rs2;
    } slot_t;

    typedef struct {
        instr_t     mem_i, ex_i, id_i;
        logic [1:0] fa, fb;
        logic       ls, st, fl;
    } vec_t;

    logic clk = 0, rst_n = 0;
    logic [4:0] rs1_ID, rs2_ID, rd_ID;
    logic rs1use_ID, rs2use_ID, Branch_ID;
    logic [1:0] hazard_optype_ID, forward_ctrl_A, forward_ctrl_B;
    logic forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_forward_unit #(.REG_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID), .hazard_optype_ID(hazard_optype_ID),
        .Branch_ID(Branch_ID), .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    slot_t  m_ex, m_mem;
    int     s_cnt, f_cnt;
    instr_t cur;
    vec_t   vecs[12];

    function automatic instr_t mk(int rs1, int rs2, int rd, bit u1, bit u2, int op, bit br);
        instr_t i;
        i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
        i.u1 = u1; i.u2 = u2; i.op = 2'(op); i.br = br;
        return i;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input instr_t i);
        cur = i;
        rs1_ID = i.rs1; rs2_ID = i.rs2; rd_ID = i.rd;
        rs1use_ID = i.u1; rs2use_ID = i.u2;
        hazard_optype_ID = i.op; Branch_ID = i.br;
    endtask

    // Reference: the pipe is two slots; a producer is a source if it writes the register read.
    function automatic bit m_stall();
        bit dep1 = cur.u1 && cur.rs1 != 0 && cur.rs1 == m_ex.rd;
        bit dep2 = cur.u2 && cur.rs2 != 0 && cur.rs2 == m_ex.rd;
        return m_ex.op == 2 && (dep1 || (dep2 && cur.op != 3));
    endfunction

    function automatic int m_fwd(logic [4:0] rs, logic used);
        if (!used || rs == 0) return 0;
        if (m_ex.rd == rs && m_ex.op == 1) return 1;
        if (m_mem.rd == rs && m_mem.op == 1) return 2;
        if (m_mem.rd == rs && m_mem.op == 2) return 3;
        return 0;
    endfunction

    task automatic check_model();
        bit st = m_stall();
        bit fl = cur.br && !st;
        bit ls = m_ex.op == 3 && m_mem.op == 2 && m_mem.rd != 0 && m_ex.rs2 == m_mem.rd;
        chk("fwd_A", int'(forward_ctrl_A), m_fwd(cur.rs1, cur.u1));
        chk("fwd_B", int'(forward_ctrl_B), m_fwd(cur.rs2, cur.u2));
        chk("fwd_ls", int'(forward_ctrl_ls), int'(ls));
        chk("pc_en", int'(PC_EN_IF), int'(!st));
        chk("fd_en", int'(reg_FD_EN), int'(!st));
        chk("de_flush", int'(reg_DE_flush), int'(st));
        chk("fd_flush", int'(reg_FD_flush), int'(fl));
        chk("stall_cnt", int'(stall_cnt), s_cnt);
        chk("flush_cnt", int'(flush_cnt), f_cnt);
    endtask

    task automatic advance_model();
        bit st = m_stall();
        if (st && s_cnt < CMAX) s_cnt++;
        if (cur.br && !st && f_cnt < CMAX) f_cnt++;
        m_mem = m_ex;
        if (st) m_ex = '{op: 2'd0, rd: 5'd0, rs2: 5'd0};
        else    m_ex = '{op: cur.op, rd: cur.rd, rs2: cur.rs2};
    endtask

    task automatic finish_cycle();
        advance_model();
        @(posedge clk); #1;
    endtask

    task automatic step(input instr_t i);
        drive(i);
        @(negedge clk);
        check_model();
        finish_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_A"}, int'(forward_ctrl_A), 0);
        chk({tag, "_B"}, int'(forward_ctrl_B), 0);
        chk({tag, "_ls"}, int'(forward_ctrl_ls), 0);
        chk({tag, "_pc_en"}, int'(PC_EN_IF), 1);
        chk({tag, "_fd_en"}, int'(reg_FD_EN), 1);
        chk({tag, "_fd_flush"}, int'(reg_FD_flush), 0);
        chk({tag, "_de_flush"}, int'(reg_DE_flush), 0);
        chk({tag, "_scnt"}, int'(stall_cnt), 0);
        chk({tag, "_fcnt"}, int'(flush_cnt), 0);
    endtask

    task automatic reset_dut(input instr_t during);
        rst_n = 0;
        drive(during);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1;
        m_ex = '{op: 2'd0, rd: 5'd0, rs2: 5'd0};
        m_mem = m_ex;
        s_cnt = 0; f_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t nop, lw5, dep, beq, lwl;
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        lw5 = mk(1, 0, 5, 1, 0, 2, 0);

        //            mem_i                    ex_i                      id_i                       fa fb ls st fl
        vecs[0]  = '{nop,                 mk(1,2,5,1,1,1,0),     mk(5,7,6,1,1,1,0),     1, 0, 0, 0, 0};
        vecs[1]  = '{nop,                 lw5,                   mk(5,0,6,1,1,1,0),     0, 0, 0, 1, 0};
        vecs[2]  = '{nop,                 lw5,                   mk(8,5,0,1,1,3,0),     0, 0, 0, 0, 0};
        vecs[3]  = '{mk(1,0,0,1,0,1,0),   mk(2,0,0,1,0,1,0),     mk(0,0,1,1,1,1,0),     0, 0, 0, 0, 0};
        vecs[4]  = '{mk(1,0,3,1,0,2,0),   mk(1,0,3,1,0,1,0),     mk(3,3,4,1,1,1,0),     1, 1, 0, 0, 0};
        vecs[5]  = '{mk(1,2,9,1,1,1,0),   nop,                   mk(9,0,4,1,0,1,0),     2, 0, 0, 0, 0};
        vecs[6]  = '{mk(1,0,9,1,0,2,0),   nop,                   mk(0,9,4,0,1,1,0),     0, 3, 0, 0, 0};
        vecs[7]  = '{nop,                 mk(1,2,5,1,1,1,0),     mk(5,0,6,0,0,1,0),     0, 0, 0, 0, 0};
        vecs[8]  = '{nop,                 nop,                   mk(1,2,0,1,1,0,1),     0, 0, 0, 0, 1};
        vecs[9]  = '{nop,                 lw5,                   mk(5,6,0,1,1,0,1),     0, 0, 0, 1, 0};
        vecs[10] = '{nop,                 lw5,                   mk(5,6,0,1,1,3,0),     0, 0, 0, 1, 0};
        vecs[11] = '{lw5,                 mk(8,5,0,1,1,3,0),     nop,                   0, 0, 1, 0, 0};

        for (int v = 0; v < 12; v++) begin
            reset_dut(nop);
            step(vecs[v].mem_i);
            step(vecs[v].ex_i);
            drive(vecs[v].id_i);
            @(negedge clk);
            chk($sformatf("vec%0d_A", v), int'(forward_ctrl_A), int'(vecs[v].fa));
            chk($sformatf("vec%0d_B", v), int'(forward_ctrl_B), int'(vecs[v].fb));
            chk($sformatf("vec%0d_ls", v), int'(forward_ctrl_ls), int'(vecs[v].ls));
            chk($sformatf("vec%0d_de", v), int'(reg_DE_flush), int'(vecs[v].st));
            chk($sformatf("vec%0d_pc", v), int'(PC_EN_IF), int'(!vecs[v].st));
            chk($sformatf("vec%0d_fd", v), int'(reg_FD_flush), int'(vecs[v].fl));
            check_model();
            finish_cycle();
        end

        // Load-use: one stall cycle, then the operand arrives from MEM load data.
        reset_dut(nop);
        dep = mk(5, 0, 6, 1, 1, 1, 0);
        step(lw5);
        step(dep);
        drive(dep);
        @(negedge clk);
        chk("lu_A_after", int'(forward_ctrl_A), 3);
        chk("lu_pc_after", int'(PC_EN_IF), 1);
        chk("lu_scnt", int'(stall_cnt), 1);
        check_model();
        finish_cycle();

        // Branch blocked by stall, then taken next cycle.
        reset_dut(nop);
        beq = mk(5, 6, 0, 1, 1, 0, 1);
        step(lw5);
        drive(beq);
        @(negedge clk);
        chk("br_stall_fd", int'(reg_FD_flush), 0);
        check_model();
        finish_cycle();
        drive(beq);
        @(negedge clk);
        chk("br_retry_fd", int'(reg_FD_flush), 1);
        chk("br_retry_fcnt0", int'(flush_cnt), 0);
        check_model();
        finish_cycle();
        step(nop);
        chk("br_fcnt", int'(flush_cnt), 1);

        // Asynchronous reset in the middle of a stall with a branch pending.
        step(lw5);
        drive(mk(5, 6, 0, 1, 1, 0, 1));
        #2;
        chk("mid_pc_pre", int'(PC_EN_IF), 0);
        rst_n = 0;
        #1;
        check_reset_outputs("mid");
        reset_dut(beq);

        // Saturation: a self-dependent load stalls every other cycle.
        lwl = mk(5, 0, 5, 1, 0, 2, 0);
        for (int k = 0; k < 140; k++) step(lwl);
        chk("sat_scnt", int'(stall_cnt), CMAX);

        // Random traffic with small register indices to provoke dependences.
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 0) reset_dut(nop);
            step(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom), $urandom_range(0, 3), ($urandom % 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
